// File: rtl/pipeline_pkg.sv
// Shared widths and control-field bit positions for the pipeline stage slice.
package pipeline_pkg;

  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CNT_W  = 16;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_UPPER     = 3;
  localparam int CTRL_SYSCALL   = 4;

endpackage

// File: rtl/pipeline_stage_sat_counter.sv
// Saturating up-counter; clr has priority over inc and the count sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count qualifying cycles, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipeline_stage.sv
// Two-entry skid-buffered pipeline register with flush and a saturating stall counter.
// Every output, including in_ready, comes straight from a flop.
module pipeline_stage
  import pipeline_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]  in_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_reg,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_r, main_valid_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_r,  main_ctrl_nxt_s;
  logic [DATA_W-1:0] main_data_r,  main_data_nxt_s;
  logic [REG_W-1:0]  main_reg_r,   main_reg_nxt_s;
  logic              skid_valid_r, skid_valid_nxt_s;
  logic [CTRL_W-1:0] skid_ctrl_r,  skid_ctrl_nxt_s;
  logic [DATA_W-1:0] skid_data_r,  skid_data_nxt_s;
  logic [REG_W-1:0]  skid_reg_r,   skid_reg_nxt_s;
  logic              in_ready_r;
  logic [1:0]        occupancy_r;
  logic              accept_s;
  logic              take_s;

  assign accept_s = in_valid & in_ready_r;
  assign take_s   = main_valid_r & out_ready;

  // Next-state of main/skid: flush wins, then refill main from skid or input, else park input in skid.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    main_ctrl_nxt_s  = main_ctrl_r;
    main_data_nxt_s  = main_data_r;
    main_reg_nxt_s   = main_reg_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_ctrl_nxt_s  = skid_ctrl_r;
    skid_data_nxt_s  = skid_data_r;
    skid_reg_nxt_s   = skid_reg_r;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s  = {CTRL_W{1'b0}};
      skid_valid_nxt_s = 1'b0;
      skid_ctrl_nxt_s  = {CTRL_W{1'b0}};
    end else if (!main_valid_r || take_s) begin
      if (skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = skid_ctrl_r;
        main_data_nxt_s  = skid_data_r;
        main_reg_nxt_s   = skid_reg_r;
        skid_valid_nxt_s = accept_s;
        skid_ctrl_nxt_s  = accept_s ? in_ctrl : {CTRL_W{1'b0}};
        skid_data_nxt_s  = in_data;
        skid_reg_nxt_s   = in_reg;
      end else if (accept_s) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = in_ctrl;
        main_data_nxt_s  = in_data;
        main_reg_nxt_s   = in_reg;
      end else begin
        // A bubble must never carry write enables downstream.
        main_valid_nxt_s = 1'b0;
        main_ctrl_nxt_s  = {CTRL_W{1'b0}};
      end
    end else if (accept_s) begin
      skid_valid_nxt_s = 1'b1;
      skid_ctrl_nxt_s  = in_ctrl;
      skid_data_nxt_s  = in_data;
      skid_reg_nxt_s   = in_reg;
    end else begin
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // State registers; in_ready and occupancy are precomputed from next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
      main_reg_r   <= {REG_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_data_r  <= {DATA_W{1'b0}};
      skid_reg_r   <= {REG_W{1'b0}};
      in_ready_r   <= 1'b1;
      occupancy_r  <= 2'd0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      main_ctrl_r  <= main_ctrl_nxt_s;
      main_data_r  <= main_data_nxt_s;
      main_reg_r   <= main_reg_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_ctrl_r  <= skid_ctrl_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      skid_reg_r   <= skid_reg_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
      occupancy_r  <= {1'b0, main_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (main_valid_r & ~out_ready),
    .cnt (stall_cnt)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_ctrl  = main_ctrl_r;
  assign out_data  = main_data_r;
  assign out_reg   = main_reg_r;
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipeline_stage.sv
// Randomized and directed bench for pipeline_stage against a queue-based reference model.
module tb_pipeline_stage;

  localparam int CW = 8;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam int NW = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [RW-1:0] r;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_reg = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_reg;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  ent_t q[$];
  int   m_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_stage #(.CTRL_W(CW), .DATA_W(DW), .REG_W(RW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_reg(in_reg),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_reg(out_reg),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [63:0] val);
    in_valid = v;
    in_ctrl  = val[CW-1:0];
    in_data  = val;
    in_reg   = val[RW-1:0];
  endtask

  // One clock: advance the model from pre-edge inputs, then sample the DUT after the edge.
  task automatic step();
    bit   acc, tk, stl;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    tk  = (q.size() > 0) && out_ready;
    stl = (q.size() > 0) && !out_ready;
    e   = '{c: in_ctrl, d: in_data, r: in_reg};
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (stl && m_cnt < CNT_MAX) m_cnt++;
      if (flush) q.delete();
      else begin
        if (tk) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    check_eq({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    check_eq({tag, ".occupancy"}, 64'(occupancy), 64'(q.size()));
    check_eq({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    if (q.size() > 0) begin
      check_eq({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(q[0].c));
      check_eq({tag, ".out_data"}, out_data,      q[0].d);
      check_eq({tag, ".out_reg"},  64'(out_reg),  64'(q[0].r));
    end else begin
      check_eq({tag, ".bubble_ctrl"}, 64'(out_ctrl), 64'd0);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; set_in(1'b1, 64'h5);
    step();
    check_eq("rst.out_data", out_data, 64'd0);
    check_eq("rst.out_reg", 64'(out_reg), 64'd0);
    compare_all("rst");
    rst = 1'b0;

    // Streaming 1..10 with constant handshakes
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 64'(i));
      step();
      check_eq("stream.data", out_data, 64'(i));
      check_eq("stream.occ_le1", 64'(occupancy <= 2'd1), 64'd1);
      compare_all("stream");
    end
    set_in(1'b0, 64'd0);
    step();
    compare_all("stream_drain");

    // Backpressure: A then B held, released in order
    out_ready = 1'b0;
    set_in(1'b1, 64'h11); step(); compare_all("bp_a");
    set_in(1'b1, 64'h22); step(); compare_all("bp_b");
    check_eq("bp.occ2", 64'(occupancy), 64'd2);
    check_eq("bp.in_ready0", 64'(in_ready), 64'd0);
    check_eq("bp.head_a", out_data, 64'h11);
    set_in(1'b0, 64'd0); out_ready = 1'b1;
    step(); compare_all("bp_rel1");
    check_eq("bp.head_b", out_data, 64'h22);
    check_eq("bp.in_ready1", 64'(in_ready), 64'd1);
    step(); compare_all("bp_rel2");
    check_eq("bp.empty", 64'(out_valid), 64'd0);

    // Flush with full stage and a pending C
    out_ready = 1'b0;
    set_in(1'b1, 64'h44); step();
    set_in(1'b1, 64'h55); step(); compare_all("fl_fill");
    set_in(1'b1, 64'h33); flush = 1'b1;
    step(); compare_all("fl");
    check_eq("fl.out_valid", 64'(out_valid), 64'd0);
    check_eq("fl.out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("fl.occ", 64'(occupancy), 64'd0);
    check_eq("fl.in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; set_in(1'b0, 64'd0); out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fl.no_c", 64'(out_valid), 64'd0);
    end

    // Saturation: 20 stalled cycles
    out_ready = 1'b0;
    set_in(1'b1, 64'h66); step();
    set_in(1'b0, 64'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      compare_all("sat");
    end
    check_eq("sat.max", 64'(stall_cnt), 64'd15);

    // Reset mid-operation with flush
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    set_in(1'b1, 64'h77); step();
    set_in(1'b1, 64'h88); step();
    set_in(1'b0, 64'd0);
    for (int i = 0; i < 20 && m_cnt < 7; i++) step();
    compare_all("mid_pre");
    check_eq("mid.cnt7", 64'(stall_cnt), 64'd7);
    check_eq("mid.occ2", 64'(occupancy), 64'd2);
    rst = 1'b1; flush = 1'b1; set_in(1'b1, 64'h99);
    step(); compare_all("mid_rst");
    check_eq("mid.out_data", out_data, 64'd0);
    check_eq("mid.out_reg", 64'(out_reg), 64'd0);
    check_eq("mid.stall", 64'(stall_cnt), 64'd0);
    check_eq("mid.in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; flush = 1'b0;

    // Random traffic, no flush
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom};
      in_reg    = RW'($urandom);
      step();
      compare_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
